// File: rtl/adder.sv
// AXI4-Lite slave wrapping a registered two-operand unsigned adder.
// Register map: 0x00 OP_A (RW), 0x04 OP_B (RW), 0x08 SUM (RO), 0x0C STATUS (RO).
// Optional feature macro ADDER_OVF_FLAG_EN adds signed overflow at STATUS bit1.
module adder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                      s1_axi_aclk,
    input  logic                      s1_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]     s1_axi_awaddr,
    input  logic                      s1_axi_awvalid,
    output logic                      s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s1_axi_wstrb,
    input  logic                      s1_axi_wvalid,
    output logic                      s1_axi_wready,
    output logic                      s1_axi_bresp,
    output logic                      s1_axi_bvalid,
    input  logic                      s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s1_axi_araddr,
    input  logic                      s1_axi_arvalid,
    output logic                      s1_axi_arready,
    output logic [DATA_WIDTH-1:0]     s1_axi_rdata,
    output logic                      s1_axi_rresp,
    output logic                      s1_axi_rvalid,
    input  logic                      s1_axi_rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned SUM_W  = DATA_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] WORD_OP_A   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] WORD_OP_B   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] WORD_SUM    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] WORD_STATUS = ADDR_WIDTH'(3);

    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  carry_q;
`ifdef ADDER_OVF_FLAG_EN
    logic                  ovf_q;
`endif

    logic [ADDR_WIDTH-1:0] aw_word_c;
    logic [ADDR_WIDTH-1:0] ar_word_c;
    logic                  wr_hs_c;
    logic                  rd_hs_c;
    logic                  wr_err_c;
    logic [SUM_W-1:0]      sum_ext_c;
    logic [DATA_WIDTH-1:0] status_c;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic                  rd_err_c;

    // Word index of each address; the byte offset bits drop out here.
    assign aw_word_c = s1_axi_awaddr >> 2;
    assign ar_word_c = s1_axi_araddr >> 2;

    assign wr_hs_c  = s1_axi_awready & s1_axi_awvalid & s1_axi_wvalid;
    assign rd_hs_c  = s1_axi_arready & s1_axi_arvalid;
    assign wr_err_c = (aw_word_c != WORD_OP_A) && (aw_word_c != WORD_OP_B);

    assign sum_ext_c = SUM_W'(op_a_q) + SUM_W'(op_b_q);

    // STATUS word assembly: carry at bit0, optional overflow at bit1.
    always_comb begin
        status_c    = '0;
        status_c[0] = carry_q;
`ifdef ADDER_OVF_FLAG_EN
        status_c[1] = ovf_q;
`endif
    end

    // Read data/response selection for the current read address.
    always_comb begin
        rd_data_c = '0;
        rd_err_c  = 1'b0;
        case (ar_word_c)
            WORD_OP_A:   rd_data_c = op_a_q;
            WORD_OP_B:   rd_data_c = op_b_q;
            WORD_SUM:    rd_data_c = sum_q;
            WORD_STATUS: rd_data_c = status_c;
            default:     rd_err_c  = 1'b1;
        endcase
    end

    // Write address/data ready: one-cycle pulse when both valids present and no response pending.
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            s1_axi_awready <= 1'b0;
            s1_axi_wready  <= 1'b0;
        end else begin
            s1_axi_awready <= s1_axi_awvalid & s1_axi_wvalid & ~s1_axi_bvalid & ~s1_axi_awready;
            s1_axi_wready  <= s1_axi_awvalid & s1_axi_wvalid & ~s1_axi_bvalid & ~s1_axi_awready;
        end
    end

    // Write response: raised after accept, held with stable bresp until bready.
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            s1_axi_bvalid <= 1'b0;
            s1_axi_bresp  <= 1'b0;
        end else if (wr_hs_c) begin
            s1_axi_bvalid <= 1'b1;
            s1_axi_bresp  <= wr_err_c;
        end else if (s1_axi_bready) begin
            s1_axi_bvalid <= 1'b0;
        end
    end

    // Operand registers, byte-masked by wstrb; read-only and unmapped writes are dropped.
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (wr_hs_c) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (s1_axi_wstrb[i]) begin
                    if (aw_word_c == WORD_OP_A) op_a_q[8*i +: 8] <= s1_axi_wdata[8*i +: 8];
                    if (aw_word_c == WORD_OP_B) op_b_q[8*i +: 8] <= s1_axi_wdata[8*i +: 8];
                end
            end
        end
    end

    // Result registers track the operands one cycle behind.
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_ext_c[DATA_WIDTH-1:0];
            carry_q <= sum_ext_c[DATA_WIDTH];
        end
    end

`ifdef ADDER_OVF_FLAG_EN
    // Signed overflow: operands agree in sign and the sum does not.
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= (op_a_q[DATA_WIDTH-1] == op_b_q[DATA_WIDTH-1]) &&
                     (sum_ext_c[DATA_WIDTH-1] != op_a_q[DATA_WIDTH-1]);
        end
    end
`endif

    // Read address ready: one-cycle pulse when no read data is pending.
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            s1_axi_arready <= 1'b0;
        end else begin
            s1_axi_arready <= s1_axi_arvalid & ~s1_axi_rvalid & ~s1_axi_arready;
        end
    end

    // Read data channel: captured on accept, held until rready.
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            s1_axi_rvalid <= 1'b0;
            s1_axi_rdata  <= '0;
            s1_axi_rresp  <= 1'b0;
        end else if (rd_hs_c) begin
            s1_axi_rvalid <= 1'b1;
            s1_axi_rdata  <= rd_data_c;
            s1_axi_rresp  <= rd_err_c;
        end else if (s1_axi_rready) begin
            s1_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Directed + randomized bench for the AXI4-Lite adder; reference results come
// from plain 64-bit arithmetic on a shadow copy of the operands.
module tb_adder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rresp;
    logic        rvalid;
    logic        rready;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [31:0] rd;
    logic        rsp;
    logic        got;
    logic [31:0] old_sum;

    adder #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .s1_axi_aclk    (clk),
        .s1_axi_aresetn (rst_n),
        .s1_axi_awaddr  (awaddr),
        .s1_axi_awvalid (awvalid),
        .s1_axi_awready (awready),
        .s1_axi_wdata   (wdata),
        .s1_axi_wstrb   (wstrb),
        .s1_axi_wvalid  (wvalid),
        .s1_axi_wready  (wready),
        .s1_axi_bresp   (bresp),
        .s1_axi_bvalid  (bvalid),
        .s1_axi_bready  (bready),
        .s1_axi_araddr  (araddr),
        .s1_axi_arvalid (arvalid),
        .s1_axi_arready (arready),
        .s1_axi_rdata   (rdata),
        .s1_axi_rresp   (rresp),
        .s1_axi_rvalid  (rvalid),
        .s1_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_sum(input logic [31:0] a, input logic [31:0] b);
        longint unsigned u;
        u = longint'(a) + longint'(b);
        return u[31:0];
    endfunction

    function automatic logic [31:0] exp_status(input logic [31:0] a, input logic [31:0] b);
        longint unsigned u;
        longint          s;
        logic [31:0]     st;
        u  = longint'(a) + longint'(b);
        s  = longint'($signed(a)) + longint'($signed(b));
        st = '0;
        st[0] = (u >= 64'h1_0000_0000);
`ifdef ADDER_OVF_FLAG_EN
        st[1] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
        if (s == 0) st[1] = 1'b0;
`endif
        return st;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = old;
        for (int k = 0; k < 4; k++) if (s[k]) m[8*k +: 8] = d[8*k +: 8];
        return m;
    endfunction

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic resp);
        logic ok;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        check("aw_accept", 32'(ok), 32'd1);
        check("w_ready_with_aw", 32'(wready), 32'(awready));
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("b_valid_after_accept", 32'(bvalid), 32'd1);
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("b_valid_cleared", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic resp);
        logic ok;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        check("ar_accept", 32'(ok), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("r_valid_after_accept", 32'(rvalid), 32'd1);
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("r_valid_cleared", 32'(rvalid), 32'd0);
    endtask

    task automatic wr_model(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic r;
        axi_write(addr, data, strb, r);
        check("bresp_operand", 32'(r), 32'd0);
        if (addr[7:2] == 6'd0) m_a = merge(m_a, data, strb);
        if (addr[7:2] == 6'd1) m_b = merge(m_b, data, strb);
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] addr, input logic [31:0] exp,
                             input logic exp_resp);
        logic [31:0] d;
        logic        r;
        axi_read(addr, d, r);
        check(tag, d, exp);
        check({tag, "_resp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic check_result(input string tag);
        rd_expect({tag, "_sum"}, 8'h08, exp_sum(m_a, m_b), 1'b0);
        rd_expect({tag, "_status"}, 8'h0C, exp_status(m_a, m_b), 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        m_a = '0; m_b = '0;
        repeat (3) @(negedge clk);

        // Outputs during reset
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resps", {30'd0, bresp, rresp}, 32'd0);
        rst_n = 1'b1;

        // Registers after reset
        rd_expect("rst_op_a", 8'h00, 32'd0, 1'b0);
        rd_expect("rst_op_b", 8'h04, 32'd0, 1'b0);
        check_result("rst");

        // Basic addition
        wr_model(8'h00, 32'd23, 4'hF);
        wr_model(8'h04, 32'd30, 4'hF);
        check_result("basic");
        check("basic_literal", exp_sum(m_a, m_b), 32'd53);

        // Carry out
        wr_model(8'h00, 32'hFFFF_FFFF, 4'hF);
        wr_model(8'h04, 32'd2, 4'hF);
        check_result("carry");

        // Byte strobes
        wr_model(8'h00, 32'h1122_3344, 4'hF);
        wr_model(8'h00, 32'h0000_00AB, 4'b0001);
        rd_expect("strobe_op_a", 8'h00, m_a, 1'b0);
        rd_expect("strobe_literal", 8'h00, 32'h1122_33AB, 1'b0);

        // Writes to read-only / unmapped, unmapped read, low address bits ignored
        old_sum = exp_sum(m_a, m_b);
        axi_write(8'h08, 32'h1234, 4'hF, rsp);
        check("ro_sum_bresp", 32'(rsp), 32'd1);
        axi_write(8'h0C, 32'h3, 4'hF, rsp);
        check("ro_status_bresp", 32'(rsp), 32'd1);
        axi_write(8'h40, 32'hDEAD, 4'hF, rsp);
        check("unmapped_bresp", 32'(rsp), 32'd1);
        rd_expect("ro_sum_unchanged", 8'h08, old_sum, 1'b0);
        rd_expect("unmapped_read", 8'h14, 32'd0, 1'b1);
        rd_expect("low_bits_ignored", 8'h0B, old_sum, 1'b0);

        // Signed overflow case
        wr_model(8'h00, 32'h7FFF_FFFF, 4'hF);
        wr_model(8'h04, 32'd1, 4'hF);
        check_result("ovf");

        // bready held low: bvalid held, no new write accepted
        @(negedge clk);
        awaddr = 8'h04; wdata = 32'd5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready) begin got = 1'b1; break; end
        end
        check("hold_accept", 32'(got), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_bvalid", 32'(bvalid), 32'd1);
            check("hold_awready", 32'(awready), 32'd0);
            check("hold_bresp", 32'(bresp), 32'd0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready) begin got = 1'b1; break; end
        end
        check("hold_second_accept", 32'(got), 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("hold_second_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        m_b = 32'd5;
        check_result("hold");

        // Simultaneous read of SUM and operand write
        wr_model(8'h00, 32'd100, 4'hF);
        wr_model(8'h04, 32'd200, 4'hF);
        old_sum = exp_sum(m_a, m_b);
        @(negedge clk);
        awaddr = 8'h00; wdata = 32'd7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h08; arvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready || arready) begin got = 1'b1; break; end
        end
        check("rw_accept", 32'(got), 32'd1);
        check("rw_same_edge", {30'd0, awready, arready}, 32'd3);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_both_valid", {30'd0, bvalid, rvalid}, 32'd3);
        check("rw_pre_write_sum", rdata, old_sum);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        m_a = 32'd7;
        check_result("rw_after");

        // Randomized operands and strobes
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [3:0]  s;
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = ~a + 32'd1;
            if (i % 4 == 1) begin a = 32'h8000_0000 | a; b = 32'h8000_0000 | b; end
            wr_model(8'h00, a, 4'hF);
            wr_model(8'h04, b, 4'hF);
            check_result("rand");
            s = 4'($urandom_range(0, 15));
            wr_model(8'h04, $urandom, s);
            rd_expect("rand_strobe_op_b", 8'h04, m_b, 1'b0);
            check_result("rand_strobe");
            rd_expect("rand_unmapped", 8'($urandom_range(16, 255)), 32'd0, 1'b1);
        end

        // Reset mid-transaction
        @(negedge clk);
        awaddr = 8'h00; wdata = 32'hCAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready) begin got = 1'b1; break; end
        end
        check("mid_accept", 32'(got), 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("mid_bvalid", 32'(bvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_a = '0; m_b = '0;
        rd_expect("post_rst_op_a", 8'h00, 32'd0, 1'b0);
        rd_expect("post_rst_op_b", 8'h04, 32'd0, 1'b0);
        check_result("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
